// File: rtl/freesched_pkg.sv
// Shared types and constants for the freemachine pass scheduler.
// Address/data defaults are used when the top-level parameters are not overridden.
package freesched_pkg;

  localparam int PASS_W = 8;

  localparam int ROW_W_DEF  = 8;
  localparam int COL_W_DEF  = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } sched_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RD   = 2'd2
  } arb_phase_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping at N.
// The caller owns and advances the pointer.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  // Scan N slots starting at ptr; the first active slot wins.
  always_comb begin
    logic [IDX_W:0]   pos_s;
    logic [IDX_W-1:0] idx_s;
    logic             hit_s;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    pos_s     = '0;
    idx_s     = '0;
    hit_s     = 1'b0;
    for (int i = 0; i < N; i++) begin
      pos_s     = {1'b0, ptr} + (IDX_W + 1)'(i);
      pos_s     = (pos_s >= (IDX_W + 1)'(N)) ? (pos_s - (IDX_W + 1)'(N)) : pos_s;
      idx_s     = pos_s[IDX_W-1:0];
      hit_s     = ~gnt_valid & req[idx_s];
      gnt[idx_s] = hit_s;
      gnt_idx   = hit_s ? idx_s : gnt_idx;
      gnt_valid = gnt_valid | hit_s;
    end
  end

endmodule

// File: rtl/freemachine_sched.sv
// Pass scheduler and single-port bank arbiter for N_MACH freemachine engines.
// Optional FREESCHED_STATS_EN adds a 32-bit completed-write counter output.
module freemachine_sched
  import freesched_pkg::*;
#(
  parameter int N_MACH     = 4,
  parameter int ROW_W      = ROW_W_DEF,
  parameter int COL_W      = COL_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_PASSES = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [PASS_W-1:0]          pass_count,
  output logic [N_MACH-1:0]          m_run,
  output logic [N_MACH-1:0]          m_ack,
  input  logic [N_MACH-1:0]          m_changed,
  input  logic [N_MACH-1:0]          m_done,
  input  logic [N_MACH-1:0]          m_rd_en,
  input  logic [N_MACH-1:0]          m_wr_en,
  input  logic [N_MACH*ROW_W-1:0]    m_row,
  input  logic [N_MACH*COL_W-1:0]    m_col,
  input  logic [N_MACH*DATA_W-1:0]   m_wdata,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ROW_W-1:0]           mem_row,
  output logic [COL_W-1:0]           mem_col,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [DATA_W-1:0]          mem_rdata
`ifdef FREESCHED_STATS_EN
  ,
  output logic [31:0]                write_count
`endif
);

  localparam int IDX_W = (N_MACH > 1) ? $clog2(N_MACH) : 1;
  localparam logic [PASS_W-1:0] PASS_CAP = PASS_W'(MAX_PASSES);

  sched_state_e         state_r;
  arb_phase_e           arb_r;
  logic                 busy_r;
  logic                 done_r;
  logic [PASS_W-1:0]    pass_count_r;
  logic [N_MACH-1:0]    m_run_r;
  logic [N_MACH-1:0]    m_ack_r;
  logic [DATA_W-1:0]    m_rdata_r;
  logic                 mem_req_r;
  logic                 mem_we_r;
  logic [ROW_W-1:0]     mem_row_r;
  logic [COL_W-1:0]     mem_col_r;
  logic [DATA_W-1:0]    mem_wdata_r;
  logic [IDX_W-1:0]     ptr_r;
  logic [IDX_W-1:0]     win_idx_r;
  logic [N_MACH-1:0]    win_oh_r;
  logic                 changed_r;

  logic [N_MACH-1:0]    req_s;
  logic [N_MACH-1:0]    gnt_s;
  logic [IDX_W-1:0]     gnt_idx_s;
  logic                 gnt_valid_s;
  logic [IDX_W-1:0]     ptr_next_s;
  logic [ROW_W-1:0]     sel_row_s;
  logic [COL_W-1:0]     sel_col_s;
  logic [DATA_W-1:0]    sel_wdata_s;
  logic                 sel_we_s;

`ifdef FREESCHED_STATS_EN
  logic [31:0]          wr_count_r;
  assign write_count = wr_count_r;
`endif

  // Engines already done are masked even if their request lines stay high.
  assign req_s      = (m_rd_en | m_wr_en) & ~m_done;
  assign ptr_next_s = (win_idx_r == IDX_W'(N_MACH - 1)) ? '0 : (win_idx_r + IDX_W'(1));

  rr_arbiter #(
    .N     (N_MACH),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req_s),
    .ptr       (ptr_r),
    .gnt       (gnt_s),
    .gnt_idx   (gnt_idx_s),
    .gnt_valid (gnt_valid_s)
  );

  // Mux the winning engine's address, data and direction.
  always_comb begin
    sel_row_s   = '0;
    sel_col_s   = '0;
    sel_wdata_s = '0;
    for (int i = 0; i < N_MACH; i++) begin
      sel_row_s   = sel_row_s   | (m_row[i*ROW_W +: ROW_W]     & {ROW_W{gnt_s[i]}});
      sel_col_s   = sel_col_s   | (m_col[i*COL_W +: COL_W]     & {COL_W{gnt_s[i]}});
      sel_wdata_s = sel_wdata_s | (m_wdata[i*DATA_W +: DATA_W] & {DATA_W{gnt_s[i]}});
    end
    sel_we_s = |(gnt_s & m_wr_en);
  end

  // Pass FSM and bank arbiter; all outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      arb_r        <= ARB_IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_count_r <= '0;
      m_run_r      <= '0;
      m_ack_r      <= '0;
      m_rdata_r    <= '0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_row_r    <= '0;
      mem_col_r    <= '0;
      mem_wdata_r  <= '0;
      ptr_r        <= '0;
      win_idx_r    <= '0;
      win_oh_r     <= '0;
      changed_r    <= 1'b0;
`ifdef FREESCHED_STATS_EN
      wr_count_r   <= 32'd0;
`endif
    end else begin
      done_r  <= 1'b0;
      m_run_r <= '0;
      m_ack_r <= '0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r      <= LAUNCH;
            busy_r       <= 1'b1;
            pass_count_r <= '0;
            m_run_r      <= '1;
`ifdef FREESCHED_STATS_EN
            wr_count_r   <= 32'd0;
`endif
          end
        end
        LAUNCH: begin
          pass_count_r <= pass_count_r + PASS_W'(1);
          arb_r        <= ARB_IDLE;
          state_r      <= RUN;
        end
        RUN: begin
          if (&m_done) begin
            // Any in-flight transaction is dropped: no engine is waiting on it.
            changed_r <= |m_changed;
            arb_r     <= ARB_IDLE;
            mem_req_r <= 1'b0;
            state_r   <= CHECK;
          end else begin
            case (arb_r)
              ARB_IDLE: begin
                if (gnt_valid_s) begin
                  win_idx_r   <= gnt_idx_s;
                  win_oh_r    <= gnt_s;
                  mem_we_r    <= sel_we_s;
                  mem_row_r   <= sel_row_s;
                  mem_col_r   <= sel_col_s;
                  mem_wdata_r <= sel_wdata_s;
                  mem_req_r   <= 1'b1;
                  arb_r       <= ARB_REQ;
                end
              end
              ARB_REQ: begin
                if (mem_gnt) begin
                  mem_req_r <= 1'b0;
                  if (mem_we_r) begin
                    m_ack_r <= win_oh_r;
                    ptr_r   <= ptr_next_s;
                    arb_r   <= ARB_IDLE;
`ifdef FREESCHED_STATS_EN
                    wr_count_r <= wr_count_r + 32'd1;
`endif
                  end else begin
                    arb_r <= ARB_RD;
                  end
                end
              end
              ARB_RD: begin
                if (mem_rvalid) begin
                  m_rdata_r <= mem_rdata;
                  m_ack_r   <= win_oh_r;
                  ptr_r     <= ptr_next_s;
                  arb_r     <= ARB_IDLE;
                end
              end
              default: begin
                mem_req_r <= 1'b0;
                arb_r     <= ARB_IDLE;
              end
            endcase
          end
        end
        CHECK: begin
          if (changed_r && (pass_count_r < PASS_CAP)) begin
            state_r <= LAUNCH;
            m_run_r <= '1;
          end else begin
            state_r <= DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          arb_r     <= ARB_IDLE;
          busy_r    <= 1'b0;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign pass_count = pass_count_r;
  assign m_run      = m_run_r;
  assign m_ack      = m_ack_r;
  assign m_rdata    = m_rdata_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_row    = mem_row_r;
  assign mem_col    = mem_col_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_freemachine_sched.sv
// Directed bench for freemachine_sched: 4 engines, pass cap 3, narrow addresses.
// Engine i uses row i+1 and column i+5 throughout.
module tb_freemachine_sched;

  localparam int N  = 4;
  localparam int RW = 4;
  localparam int CW = 4;
  localparam int DW = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic            busy, done;
  logic [7:0]      pass_count;
  logic [N-1:0]    m_run, m_ack;
  logic [N-1:0]    m_changed, m_done, m_rd_en, m_wr_en;
  logic [N*RW-1:0] m_row;
  logic [N*CW-1:0] m_col;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rdata;
  logic            mem_req, mem_we;
  logic [RW-1:0]   mem_row;
  logic [CW-1:0]   mem_col;
  logic [DW-1:0]   mem_wdata;
  logic            mem_gnt, mem_rvalid;
  logic [DW-1:0]   mem_rdata;
`ifdef FREESCHED_STATS_EN
  logic [31:0]     write_count;
`endif

  int checks = 0;
  int failures = 0;
  int run_pulses = 0;
  int pulses0;
  int n;

  freemachine_sched #(
    .N_MACH(N), .ROW_W(RW), .COL_W(CW), .DATA_W(DW), .MAX_PASSES(3)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .pass_count(pass_count), .m_run(m_run), .m_ack(m_ack),
    .m_changed(m_changed), .m_done(m_done), .m_rd_en(m_rd_en), .m_wr_en(m_wr_en),
    .m_row(m_row), .m_col(m_col), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_row(mem_row), .mem_col(mem_col),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
`ifdef FREESCHED_STATS_EN
    , .write_count(write_count)
`endif
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (m_run != '0) run_pulses++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered in LAUNCH; leaves right after the CHECK edge (LAUNCH or DONE).
  task automatic pass_body(input logic [N-1:0] chg);
    m_done = 4'h0; m_changed = 4'h0; tick();
    m_done = 4'hF; m_changed = chg;  tick();
    m_changed = 4'h0;                tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    m_changed = '0; m_done = 4'hF; m_rd_en = '0; m_wr_en = '0;
    m_row = 16'h4321; m_col = 16'h8765; m_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'h00;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass_count), 32'd0);
    check("rst_run", 32'(m_run), 32'd0);
    check("rst_ack", 32'(m_ack), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    reset = 1'b0;
    tick();

    // Single pass: engines 0 and 1 each read once.
    start = 1'b1; tick(); start = 1'b0;
    check("s1_run", 32'(m_run), 32'hF);
    check("s1_busy", 32'(busy), 32'd1);
    m_done = 4'b1100; m_rd_en = 4'b0001; tick();
    check("s1_pass_run", 32'(pass_count), 32'd1);
    check("s1_run_off", 32'(m_run), 32'd0);
    tick();
    check("s1_req0", {mem_req, mem_we, mem_row}, {26'd0, 1'b1, 1'b0, 4'd1});
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    check("s1_req_drop", 32'(mem_req), 32'd0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 8'h3C; tick(); mem_rvalid = 1'b0;
    check("s1_ack0", 32'(m_ack), 32'h1);
    check("s1_rdata0", 32'(m_rdata), 32'h3C);
    m_rd_en = 4'b0010; m_done = 4'b1101; tick();
    check("s1_ack_pulse", 32'(m_ack), 32'h0);
    check("s1_req1", {mem_req, mem_row}, {27'd0, 1'b1, 4'd2});
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 8'h5A; tick(); mem_rvalid = 1'b0;
    check("s1_ack1", 32'(m_ack), 32'h2);
    check("s1_rdata1", 32'(m_rdata), 32'h5A);
    m_rd_en = 4'b0000; m_done = 4'hF; tick();
    check("s1_busy_check", 32'(busy), 32'd1);
    tick();
    check("s1_done", {done, busy}, 32'b10);
    check("s1_pass_final", 32'(pass_count), 32'd1);
    tick();
    check("s1_done_pulse", 32'(done), 32'd0);

    // Two passes: first reports a change, second does not.
    pulses0 = run_pulses;
    start = 1'b1; tick(); start = 1'b0;
    pass_body(4'b0001);
    check("s2_relaunch", 32'(m_run), 32'hF);
    pass_body(4'b0000);
    check("s2_done", {done, busy}, 32'b10);
    check("s2_pass", 32'(pass_count), 32'd2);
    check("s2_pulses", 32'(run_pulses - pulses0), 32'd2);
    tick();

    // Pass cap of 3 with changes every pass.
    pulses0 = run_pulses;
    start = 1'b1; tick(); start = 1'b0;
    pass_body(4'hF);
    check("s5_launch2", 32'(m_run), 32'hF);
    pass_body(4'hF);
    check("s5_launch3", 32'(m_run), 32'hF);
    pass_body(4'hF);
    check("s5_done", 32'(done), 32'd1);
    check("s5_pass", 32'(pass_count), 32'd3);
    check("s5_pulses", 32'(run_pulses - pulses0), 32'd3);
    tick();

    // Round robin over four continuous readers; reset first so pointer is 0.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    m_done = 4'h0; m_rd_en = 4'hF; mem_gnt = 1'b1; tick();
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!mem_req && n < 20) begin tick(); n++; end
      check("s3_req_seen", 32'(mem_req), 32'd1);
      check("s3_row", 32'(mem_row), 32'((k % 4) + 1));
      tick();
      tick();
      mem_rvalid = 1'b1; mem_rdata = 8'(8'h10 + k); tick(); mem_rvalid = 1'b0;
      check("s3_ack", 32'(m_ack), 32'(1 << (k % 4)));
      check("s3_rdata", 32'(m_rdata), 32'(8'h10 + k));
    end
    mem_gnt = 1'b0; m_rd_en = 4'h0; m_done = 4'hF; tick(); tick();
    check("s3_done", 32'(done), 32'd1);
    tick();

    // Engine 1 writes 0xA5 with a 5-cycle grant stall; engine 3 is done and masked.
    start = 1'b1; tick(); start = 1'b0;
    m_done = 4'b1101; m_wr_en = 4'b0010; m_rd_en = 4'b1010; m_wdata = 32'h0000A500; tick();
    tick();
    check("s4_req", {mem_req, mem_we, mem_row, mem_col, mem_wdata},
          {14'd0, 1'b1, 1'b1, 4'd2, 4'd6, 8'hA5});
    for (int s = 0; s < 5; s++) begin
      tick();
      check("s4_stable", {m_ack, mem_req, mem_we, mem_row, mem_col, mem_wdata},
            {10'd0, 4'd0, 1'b1, 1'b1, 4'd2, 4'd6, 8'hA5});
    end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    check("s4_ack", 32'(m_ack), 32'h2);
    check("s4_req_drop", 32'(mem_req), 32'd0);
    m_wr_en = 4'b0000; m_rd_en = 4'b1000; tick();
    check("s4_ack_pulse", 32'(m_ack), 32'h0);
    tick();
    check("s4_masked", 32'(mem_req), 32'd0);
    m_rd_en = 4'h0; m_done = 4'hF; tick(); tick();
    check("s4_done", 32'(done), 32'd1);
    tick();

    // Reset while waiting for read data, then a late rvalid.
    start = 1'b1; tick(); start = 1'b0;
    m_done = 4'b1110; m_rd_en = 4'b0001; tick();
    tick();
    check("s6_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    reset = 1'b1; tick();
    check("s6_rst", {busy, done, pass_count, m_run, m_ack, mem_req},
          {13'd0, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b0});
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 8'h77; tick(); mem_rvalid = 1'b0;
    check("s6_late_ack", 32'(m_ack), 32'h0);
    check("s6_late_rdata", 32'(m_rdata), 32'h0);
    m_rd_en = 4'h0; m_done = 4'hF; tick();
    check("s6_idle_busy", 32'(busy), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("s6_restart", {busy, m_run}, {27'd0, 1'b1, 4'hF});
    pass_body(4'h0);
    check("s6_done", {done, pass_count}, {23'd0, 1'b1, 8'd1});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
